blood_class_dispatcher: RTL
===========================

BLOOD_CLASS_DISPATCHER -- requirements
Module: blood_class_dispatcher

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous, active-high reset, rst; both are sampled on the rising edge of clk only.
REQ-002 The block SHALL have these ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- inValid  input  1  upstream sample valid
- bloodType  input  3  one-hot type code (001, 010 or 100)
- bloodClass  input  1  classification result for bloodType (1 = priority)
- inReady  output  1  block can accept a sample this cycle
- outValid  output  1  priority entry available at the FIFO head
- outType  output  3  bloodType of the head entry
- outReady  input  1  downstream accepts the head entry
- count0  output  8  accepted class-0 samples
- count1  output  8  accepted class-1 samples
- fifoCount  output  3  FIFO occupancy, 0 to 4
- codeError  output  1  sticky flag for a non-one-hot bloodType

Function
REQ-003 An input is accepted on a rising edge when inValid=1 and inReady=1; inValid has no effect when inReady=0.
REQ-004 inReady SHALL equal (fifoCount != 4) and is computed from registered state only.
REQ-005 A non-one-hot bloodType (000, 011, 101, 110 or 111) on an accepted input SHALL set codeError; that input is neither counted nor pushed.
REQ-006 An accepted valid input with bloodClass=0 SHALL increment count0, saturating at 255; nothing is pushed.
REQ-007 An accepted valid input with bloodClass=1 SHALL increment count1, saturating at 255, and push bloodType into the FIFO tail.
REQ-008 The FIFO SHALL be 4 entries deep, 3 bits wide and in-order, with 2-bit read/write pointers that wrap from 3 to 0.
REQ-009 outValid SHALL equal (fifoCount != 0); outType SHALL be the head entry, and SHALL be 000 when the FIFO is empty.
REQ-010 A pop SHALL occur on an edge where outValid=1 and outReady=1; the head then advances.
REQ-011 outType and outValid SHALL hold stable while outValid=1 and outReady=0.
REQ-012 Push-to-outValid latency SHALL be 1 cycle, with no fall-through: a push into an empty FIFO asserts outValid on the next cycle.
REQ-013 A simultaneous push and pop SHALL leave fifoCount unchanged and advance both pointers.
REQ-014 A pop in the same cycle as FULL does not enable a push in that cycle, because inReady was 0; the push is possible on the next cycle.
REQ-015 The occupancy FSM SHALL have states EMPTY (fifoCount 0), ACTIVE (fifoCount 1 to 3) and FULL (fifoCount 4), with these transitions:
- EMPTY to ACTIVE on a push
- ACTIVE to FULL on a push without a pop at fifoCount 3
- ACTIVE to EMPTY on a pop without a push at fifoCount 1
- FULL to ACTIVE on a pop
- otherwise hold
REQ-016 The FSM state SHALL always be consistent with fifoCount; an inconsistent or illegal encoding SHALL recover to EMPTY on the next edge.
REQ-017 Saturated counters SHALL hold at 255; a push still occurs when count1 is saturated.
REQ-018 codeError, once set, SHALL remain 1 until rst.

Reset
REQ-019 With rst=1 at a rising edge, the block SHALL clear the FSM to EMPTY, clear both pointers, fifoCount, count0, count1 and codeError, and drive outValid=0, outType=000 and inReady=1.
REQ-020 rst SHALL have priority over any simultaneous push or pop; entries in flight are discarded, and the pop in that cycle is not reported as a completed transfer.
REQ-021 FIFO storage contents need not be cleared; they are unobservable while empty.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- V1: After reset, apply one input each of 001/c0, 010/c1 and 100/c1 with outReady=0 -> count0=1, count1=2, fifoCount=2, outType=010.
- V2: Push 4 priority samples with outReady=0 -> inReady=0 and FSM FULL; a 5th inValid is ignored and counts are unchanged; one pop -> inReady=1 on the next cycle.
- V3: At fifoCount=2, push 100 and pop in the same cycle -> fifoCount stays 2 and the order is preserved.
- V4: Apply bloodType=011 with inValid=1 -> codeError=1, no counts change and no push; codeError stays 1 after 10 valid samples.
- V5: Apply 300 class-0 samples -> count0=255 (saturated); count1 and the FIFO are unaffected.
- V6: Assert rst while FULL and outReady=1 -> next cycle fifoCount=0, outValid=0 and all counters 0; the first post-reset push appears at the head with the 1-cycle latency of REQ-012.

Source files
------------

// File: rtl/blood_class_dispatcher.sv
`default_nettype none
// ============================================================================
// blood_class_dispatcher : counts classified samples, queues priority types
// Revision 1.0
// ============================================================================
module blood_class_dispatcher (
    input  logic       clk,
    input  logic       rst,
    input  logic       inValid,
    input  logic [2:0] bloodType,
    input  logic       bloodClass,
    output logic       inReady,
    output logic       outValid,
    output logic [2:0] outType,
    input  logic       outReady,
    output logic [7:0] count0,
    output logic [7:0] count1,
    output logic [2:0] fifoCount,
    output logic       codeError
);
    localparam logic [1:0] S_EMPTY  = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_FULL   = 2'd2;
    localparam logic [2:0] DEPTH    = 3'd4;
    localparam logic [7:0] CNT_MAX  = 8'hFF;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       state_bad;
    logic [2:0] mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] occ;
    logic       accept;
    logic       type_ok;
    logic       push;
    logic       pop;

    assign fifoCount = occ;
    assign accept    = inValid && inReady;
    assign type_ok   = (bloodType == 3'b001) || (bloodType == 3'b010) || (bloodType == 3'b100);
    assign push      = accept && type_ok && bloodClass;
    assign pop       = outValid && outReady;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; any disagreement with occupancy forces recovery to EMPTY
    always_comb begin
        state_bad  = 1'b0;
        state_next = state;
        case (state)
            S_EMPTY: begin
                state_bad = (occ != 3'd0);
                if (push) state_next = S_ACTIVE;
            end
            S_ACTIVE: begin
                state_bad = (occ == 3'd0) || (occ > 3'd3);
                if (push && !pop && occ == 3'd3) state_next = S_FULL;
                else if (pop && !push && occ == 3'd1) state_next = S_EMPTY;
            end
            S_FULL: begin
                state_bad = (occ != DEPTH);
                if (pop) state_next = S_ACTIVE;
            end
            default: begin
                state_bad = 1'b1;
            end
        endcase
        if (state_bad) state_next = S_EMPTY;
    end

    // Output logic
    always_comb begin
        inReady  = (occ != DEPTH);
        outValid = (occ != 3'd0);
        outType  = outValid ? mem[rd_ptr] : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (rst || state_bad) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            occ    <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            occ <= occ + {2'b00, push} - {2'b00, pop};
        end
    end

    // Storage needs no reset: entries are only visible while occupied
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bloodType;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count0    <= 8'd0;
            count1    <= 8'd0;
            codeError <= 1'b0;
        end else if (accept) begin
            if (!type_ok) begin
                codeError <= 1'b1;
            end else if (!bloodClass) begin
                if (count0 != CNT_MAX) count0 <= count0 + 8'd1;
            end else begin
                if (count1 != CNT_MAX) count1 <= count1 + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire
